step_counter_limit: RTL and testbench

Quadrature step counter for a two-channel incremental encoder (A/B). It decodes Gray-code transitions into a 16-bit up/down position count and compares the count against a loadable 16-bit limit, raising a done flag on a match. It also tracks direction reversals. Count, limit and status are readable as bytes through a simple chip-select/read peripheral bus.

---
 rtl/step_counter_limit.sv | 82 ++++++++
 tb/tb_step_counter_limit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/step_counter_limit.sv
// step_counter_limit: quadrature A/B step counter with a done-on-limit flag and a byte-wide read bus
//   clk, rst          rising-edge clock, synchronous active-high reset
//   addr, cs, rd      byte read bus; data_out is registered (1-cycle latency)
//   A, B              asynchronous encoder channels
//   limit_in          value loaded by the load_limit strobe
//   done              sticky: counter equalled a non-zero limit
module step_counter_limit #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        cs,
    input  logic        rd,
    output logic [7:0]  data_out,
    input  logic        A,
    input  logic        B,
    input  logic [15:0] limit_in,
    input  logic        load_limit,
    output logic        done
);
    logic [SYNC_STAGES-1:0] a_sr, b_sr;
    logic [1:0]  ab, prev_ab;
    logic [15:0] count, limit, off;
    logic [7:0]  inv_cnt, rd_byte, status;
    logic        dir, flag, stepped, fwd, rev, inv, rd_en, stat_rd;
    assign ab      = {a_sr[SYNC_STAGES-1], b_sr[SYNC_STAGES-1]};
    assign fwd     = (prev_ab == 2'b00 && ab == 2'b01) || (prev_ab == 2'b01 && ab == 2'b11) ||
                     (prev_ab == 2'b11 && ab == 2'b10) || (prev_ab == 2'b10 && ab == 2'b00);
    assign rev     = (prev_ab == 2'b01 && ab == 2'b00) || (prev_ab == 2'b11 && ab == 2'b01) ||
                     (prev_ab == 2'b10 && ab == 2'b11) || (prev_ab == 2'b00 && ab == 2'b10);
    assign inv     = (ab ^ prev_ab) == 2'b11;
    assign off     = addr - BASE_ADDR;
    assign rd_en   = cs && rd;
    assign stat_rd = rd_en && off == 16'd0;
    assign status  = {3'b000, ab[0], ab[1], flag, dir, done};
    always_comb begin
        rd_byte = 8'h00;
        case (off)
            16'd0:   rd_byte = status;
            16'd1:   rd_byte = limit[7:0];
            16'd2:   rd_byte = limit[15:8];
            16'd3:   rd_byte = inv_cnt;
            16'd5:   rd_byte = count[7:0];
            16'd6:   rd_byte = count[15:8];
            default: rd_byte = 8'h00;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            prev_ab  <= 2'b00;
            count    <= 16'h0000;
            limit    <= 16'h0000;
            inv_cnt  <= 8'h00;
            dir      <= 1'b0;
            flag     <= 1'b0;
            stepped  <= 1'b0;
            done     <= 1'b0;
            data_out <= 8'h00;
        end else begin
            a_sr     <= {a_sr[SYNC_STAGES-2:0], A};
            b_sr     <= {b_sr[SYNC_STAGES-2:0], B};
            prev_ab  <= ab;
            count    <= fwd ? count + 16'd1 : rev ? count - 16'd1 : count;
            inv_cnt  <= (inv && inv_cnt != 8'hFF) ? inv_cnt + 8'd1 : inv_cnt;
            dir      <= fwd ? 1'b1 : rev ? 1'b0 : dir;
            stepped  <= stepped | fwd | rev;
            // a reversal detected in the same cycle as a status read must not be lost
            flag     <= (stepped && (fwd || rev) && fwd != dir) ? 1'b1 : stat_rd ? 1'b0 : flag;
            data_out <= rd_en ? rd_byte : 8'h00;
            if (load_limit) begin
                limit <= limit_in;
                done  <= 1'b0;
            end else if (limit != 16'h0000 && count == limit) begin
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_step_counter_limit.sv
// tb_step_counter_limit: directed scoreboard bench for step_counter_limit
module tb_step_counter_limit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  data_out;
    logic        A = 1'b0;
    logic        B = 1'b0;
    logic [15:0] limit_in = 16'h0000;
    logic        load_limit = 1'b0;
    logic        done;
    int          checks = 0;
    int          errs = 0;
    logic [7:0]  q[$];

    step_counter_limit dut (
        .clk(clk), .rst(rst), .addr(addr), .cs(cs), .rd(rd), .data_out(data_out),
        .A(A), .B(B), .limit_in(limit_in), .load_limit(load_limit), .done(done)
    );

    always #5 clk = ~clk;

    task automatic rd_chk(input logic [15:0] o, input string tag);
        logic [7:0] e;
        @(negedge clk);
        addr = o;
        cs = 1'b1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0;
        rd = 1'b0;
        e = q.pop_front();
        checks++;
        assert (data_out === e) else begin
            errs++;
            $error("FAIL %s: data_out=%h expected %h", tag, data_out, e);
        end
    endtask

    task automatic exp_rd(input logic [15:0] o, input logic [7:0] e, input string tag);
        q.push_back(e);
        rd_chk(o, tag);
    endtask

    task automatic chk_done(input logic e, input string tag);
        checks++;
        assert (done === e) else begin
            errs++;
            $error("FAIL %s: done=%b expected %b", tag, done, e);
        end
    endtask

    task automatic set_ab(input logic [1:0] v);
        @(negedge clk);
        {A, B} = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cw_cycle();
        set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
    endtask

    task automatic ccw_cycle();
        set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {A, B} = 2'b00;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        limit_in = v;
        load_limit = 1'b1;
        @(posedge clk);
        #1;
        load_limit = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset();
        chk_done(1'b0, "reset_done");
        for (int i = 0; i < 8; i++) exp_rd(16'(i), 8'h00, "reset_reg");

        repeat (3) cw_cycle();
        repeat (3) ccw_cycle();
        repeat (3) cw_cycle();
        exp_rd(16'h5, 8'h0C, "cnt_lo_12");
        exp_rd(16'h6, 8'h00, "cnt_hi_12");
        exp_rd(16'h0, 8'h06, "status_flag_set");
        exp_rd(16'h0, 8'h02, "status_flag_clr");
        chk_done(1'b0, "limit0_no_done");

        set_ab(2'b11);
        exp_rd(16'h3, 8'h01, "invalid_cnt");
        exp_rd(16'h5, 8'h0C, "cnt_after_invalid");
        exp_rd(16'h0, 8'h1A, "status_ab11");
        @(negedge clk);
        {A, B} = 2'b10;
        @(posedge clk);
        do_reset();
        chk_done(1'b0, "midrot_reset_done");
        for (int i = 0; i < 7; i++) exp_rd(16'(i), 8'h00, "midrot_reset_reg");

        load(16'h0004);
        exp_rd(16'h1, 8'h04, "limit_lo");
        exp_rd(16'h2, 8'h00, "limit_hi");
        set_ab(2'b01); set_ab(2'b11); set_ab(2'b10);
        chk_done(1'b0, "done_before_limit");
        set_ab(2'b00);
        chk_done(1'b1, "done_at_limit");
        repeat (2) cw_cycle();
        chk_done(1'b1, "done_sticky");
        exp_rd(16'h5, 8'h0C, "cnt_past_limit");
        load(16'h0100);
        chk_done(1'b0, "done_cleared_by_load");

        do_reset();
        set_ab(2'b10);
        exp_rd(16'h5, 8'hFF, "wrap_lo");
        exp_rd(16'h6, 8'hFF, "wrap_hi");
        exp_rd(16'h0, 8'h08, "status_ccw");
        set_ab(2'b00);
        exp_rd(16'h5, 8'h00, "unwrap_lo");
        exp_rd(16'h6, 8'h00, "unwrap_hi");
        exp_rd(16'h0, 8'h06, "status_reversal");

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
